// File: rtl/bist_pkg.sv
// Shared types for the SRAM BIST controller and its read checker.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_PG,
        RUN,
        DRAIN,
        DONE
    } bist_ctrl_state_t;

    // States in which the BIST owns the SRAM port.
    function automatic logic is_busy_state(input bist_ctrl_state_t s);
        return (s == RESET_PG) || (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/bist_read_checker.sv
// Read-latency pipeline for BIST reads, data comparator, saturating fail
// counter and capture of the first failing address/expected/actual data.
module bist_read_checker
    import bist_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int FAIL_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [DATA_WIDTH-1:0]     push_check,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr,
    output logic [DATA_WIDTH-1:0]     first_fail_expected,
    output logic [DATA_WIDTH-1:0]     first_fail_actual
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] check;
    } rd_entry_t;

    rd_entry_t pipe_q [READ_LATENCY];
    rd_entry_t pipe_d [READ_LATENCY];
    rd_entry_t head;
    logic      mismatch;

    logic [FAIL_CNT_WIDTH-1:0] fail_count_q, fail_count_d;
    logic                      first_seen_q, first_seen_d;
    logic [ADDR_WIDTH-1:0]     ff_addr_q, ff_addr_d;
    logic [DATA_WIDTH-1:0]     ff_exp_q, ff_exp_d;
    logic [DATA_WIDTH-1:0]     ff_act_q, ff_act_d;

    // Entry pushed with the read request leaves the last stage exactly when
    // its read data is valid on rdata.
    always_comb begin
        pipe_d[0].valid = push;
        pipe_d[0].addr  = push_addr;
        pipe_d[0].check = push_check;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign head     = pipe_q[READ_LATENCY-1];
    assign mismatch = head.valid && (rdata != head.check);

    always_comb begin
        fail_count_d = fail_count_q;
        first_seen_d = first_seen_q;
        ff_addr_d    = ff_addr_q;
        ff_exp_d     = ff_exp_q;
        ff_act_d     = ff_act_q;
        if (clear) begin
            fail_count_d = '0;
            first_seen_d = 1'b0;
            ff_addr_d    = '0;
            ff_exp_d     = '0;
            ff_act_d     = '0;
        end else if (mismatch) begin
            if (fail_count_q != '1) begin
                fail_count_d = fail_count_q + 1'b1;
            end
            if (!first_seen_q) begin
                first_seen_d = 1'b1;
                ff_addr_d    = head.addr;
                ff_exp_d     = head.check;
                ff_act_d     = rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid bits need reset; address/check payload is
            // ignored while invalid, so it stays un-reset to keep the reset tree small.
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
            fail_count_q <= '0;
            first_seen_q <= 1'b0;
            ff_addr_q    <= '0;
            ff_exp_q     <= '0;
            ff_act_q     <= '0;
        end else begin
            pipe_q       <= pipe_d;
            fail_count_q <= fail_count_d;
            first_seen_q <= first_seen_d;
            ff_addr_q    <= ff_addr_d;
            ff_exp_q     <= ff_exp_d;
            ff_act_q     <= ff_act_d;
        end
    end

    assign fail_count          = fail_count_q;
    assign first_fail_addr     = ff_addr_q;
    assign first_fail_expected = ff_exp_q;
    assign first_fail_actual   = ff_act_q;

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer for one SRAM macro: drives a pattern generator, owns the
// SRAM port while a test runs and reports pass/fail with first-fail details.
module bist_controller
    import bist_pkg::*;
#(
    parameter int MAX_ADDR       = 255,
    parameter int ADDR_WIDTH     = $clog2(MAX_ADDR),
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int FAIL_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr,
    output logic [DATA_WIDTH-1:0]     first_fail_expected,
    output logic [DATA_WIDTH-1:0]     first_fail_actual,
    output logic                      pg_en,
    output logic                      pg_rst,
    input  logic [ADDR_WIDTH-1:0]     pg_addr,
    input  logic [DATA_WIDTH-1:0]     pg_data,
    input  logic [DATA_WIDTH-1:0]     pg_check,
    input  logic [MASK_WIDTH-1:0]     pg_wmask,
    input  logic                      pg_we,
    input  logic                      pg_re,
    input  logic                      pg_done,
    input  logic [ADDR_WIDTH-1:0]     func_addr,
    input  logic [DATA_WIDTH-1:0]     func_wdata,
    input  logic [MASK_WIDTH-1:0]     func_wmask,
    input  logic                      func_we,
    input  logic                      func_re,
    output logic                      func_grant,
    output logic [ADDR_WIDTH-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0]     sram_wdata,
    output logic [MASK_WIDTH-1:0]     sram_wmask,
    output logic                      sram_we,
    output logic                      sram_re,
    input  logic [DATA_WIDTH-1:0]     sram_rdata
);

    localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);

    bist_ctrl_state_t     state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 run_active;
    logic                 bist_read;

    assign run_active = (state_q == RUN) && !pg_done;
    assign bist_read  = pg_re && run_active;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = RESET_PG;
            RESET_PG:   state_d = RUN;
            RUN: begin
                if (pg_done) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = is_busy_state(state_d);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Port ownership: functional requests are dropped, not queued, while busy.
    always_comb begin
        if (busy_q) begin
            sram_addr  = pg_addr;
            sram_wdata = pg_data;
            sram_wmask = pg_wmask;
            sram_we    = pg_we && run_active;
            sram_re    = bist_read;
        end else begin
            sram_addr  = func_addr;
            sram_wdata = func_wdata;
            sram_wmask = func_wmask;
            sram_we    = func_we;
            sram_re    = func_re;
        end
    end

    assign func_grant = !busy_q;
    assign pg_en      = run_active;
    assign pg_rst     = rst || (state_q == RESET_PG);
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = done_q && (fail_count == '0);

    bist_read_checker #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .READ_LATENCY   (READ_LATENCY),
        .FAIL_CNT_WIDTH (FAIL_CNT_WIDTH)
    ) u_checker (
        .clk                 (clk),
        .rst                 (rst),
        .clear               (state_q == RESET_PG),
        .push                (bist_read),
        .push_addr           (pg_addr),
        .push_check          (pg_check),
        .rdata               (sram_rdata),
        .fail_count          (fail_count),
        .first_fail_addr     (first_fail_addr),
        .first_fail_expected (first_fail_expected),
        .first_fail_actual   (first_fail_actual)
    );

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench: lane 0 is READ_LATENCY=1, lane 1 is READ_LATENCY=3, each with
// its own zero/one pattern generator and fault-injectable ideal SRAM model.
module tb_bist_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start [2];
    logic        busy [2], done [2], pass [2], func_grant [2], pg_en [2], pg_rst [2];
    logic [15:0] fail_count [2];
    logic [1:0]  ffa [2];
    logic [7:0]  ffe [2], ffact [2];
    logic [1:0]  pg_addr [2];
    logic [7:0]  pg_data [2], pg_check [2];
    logic [0:0]  pg_wmask [2];
    logic        pg_we [2], pg_re [2], pg_done [2];
    logic [1:0]  func_addr;
    logic [7:0]  func_wdata;
    logic [0:0]  func_wmask;
    logic        func_we, func_re;
    logic [1:0]  sram_addr [2];
    logic [7:0]  sram_wdata [2];
    logic [0:0]  sram_wmask [2];
    logic        sram_we [2], sram_re [2];
    logic [7:0]  sram_rdata [2];

    logic [4:0]  pg_cnt [2];
    logic [7:0]  mem [2][4];
    logic [7:0]  rpipe [2][3];
    logic [7:0]  stuck [2][4];

    int tests_run = 0;
    int tests_failed = 0;

    bist_controller #(.MAX_ADDR(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(1),
                      .READ_LATENCY(1), .FAIL_CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_count(fail_count[0]), .first_fail_addr(ffa[0]), .first_fail_expected(ffe[0]),
        .first_fail_actual(ffact[0]), .pg_en(pg_en[0]), .pg_rst(pg_rst[0]), .pg_addr(pg_addr[0]),
        .pg_data(pg_data[0]), .pg_check(pg_check[0]), .pg_wmask(pg_wmask[0]), .pg_we(pg_we[0]),
        .pg_re(pg_re[0]), .pg_done(pg_done[0]), .func_addr(func_addr), .func_wdata(func_wdata),
        .func_wmask(func_wmask), .func_we(func_we), .func_re(func_re), .func_grant(func_grant[0]),
        .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_wmask(sram_wmask[0]),
        .sram_we(sram_we[0]), .sram_re(sram_re[0]), .sram_rdata(sram_rdata[0])
    );

    bist_controller #(.MAX_ADDR(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .MASK_WIDTH(1),
                      .READ_LATENCY(3), .FAIL_CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_count(fail_count[1]), .first_fail_addr(ffa[1]), .first_fail_expected(ffe[1]),
        .first_fail_actual(ffact[1]), .pg_en(pg_en[1]), .pg_rst(pg_rst[1]), .pg_addr(pg_addr[1]),
        .pg_data(pg_data[1]), .pg_check(pg_check[1]), .pg_wmask(pg_wmask[1]), .pg_we(pg_we[1]),
        .pg_re(pg_re[1]), .pg_done(pg_done[1]), .func_addr(func_addr), .func_wdata(func_wdata),
        .func_wmask(func_wmask), .func_we(func_we), .func_re(func_re), .func_grant(func_grant[1]),
        .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_wmask(sram_wmask[1]),
        .sram_we(sram_we[1]), .sram_re(sram_re[1]), .sram_rdata(sram_rdata[1])
    );

    // Zero/one patgen: write 00 to 0..3, read 00, write FF to 0..3, read FF.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            pg_done[l]  = (pg_cnt[l] == 5'd16);
            pg_addr[l]  = pg_cnt[l][1:0];
            pg_data[l]  = pg_cnt[l][3] ? 8'hFF : 8'h00;
            pg_check[l] = pg_cnt[l][3] ? 8'hFF : 8'h00;
            pg_wmask[l] = 1'b1;
            pg_we[l]    = !pg_cnt[l][2] && !pg_done[l];
            pg_re[l]    = pg_cnt[l][2] && !pg_done[l];
        end
        sram_rdata[0] = rpipe[0][0];
        sram_rdata[1] = rpipe[1][2];
    end

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (pg_rst[l]) pg_cnt[l] <= 5'd0;
            else if (pg_en[l]) pg_cnt[l] <= pg_cnt[l] + 5'd1;
            for (int k = 2; k > 0; k--) rpipe[l][k] <= rpipe[l][k-1];
            rpipe[l][0] <= sram_re[l] ? (mem[l][sram_addr[l]] & ~stuck[l][sram_addr[l]]) : 8'hA5;
            if (sram_we[l] && sram_wmask[l][0]) mem[l][sram_addr[l]] <= sram_wdata[l];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start sampled at edge 0; observations are taken #1 after each edge.
    task automatic do_run(input int lane, input int mid_start, output int ops, output int done_edge,
                          output int rpg, output logic busy1, output int we_err);
        ops = 0; done_edge = -1; rpg = 0; busy1 = 1'b0; we_err = 0;
        start[lane] = 1'b1;
        tick();
        start[lane] = 1'b0;
        for (int e = 0; e <= 200; e++) begin
            if (pg_rst[lane]) rpg++;
            if (busy[lane] && (sram_we[lane] || sram_re[lane])) ops++;
            if (e == 1) busy1 = busy[lane];
            if (busy[lane] && (func_grant[lane] ||
                sram_we[lane] !== (pg_we[lane] && e >= 1 && e <= 16))) we_err++;
            if (done[lane]) begin
                done_edge = e;
                break;
            end
            start[lane] = (e == mid_start);
            tick();
        end
        start[lane] = 1'b0;
    endtask

    task automatic clear_faults();
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 4; a++) stuck[l][a] = 8'h00;
    endtask

    task automatic test_reset();
        tests_run++;
        if (pg_rst[0] !== 1'b1) begin
            tests_failed++; $display("FAIL reset_pg_rst: got %0b want 1", pg_rst[0]);
        end
        rst = 1'b0;
        tick();
        for (int l = 0; l < 2; l++) begin
            tests_run++;
            if ({busy[l], done[l], pass[l], func_grant[l], pg_rst[l]} !== 5'b00010) begin
                tests_failed++;
                $display("FAIL reset_flags lane%0d: got busy/done/pass/grant/pgrst=%b want 00010",
                         l, {busy[l], done[l], pass[l], func_grant[l], pg_rst[l]});
            end
            tests_run++;
            if (fail_count[l] !== 16'd0 || ffa[l] !== 2'd0 || ffe[l] !== 8'd0 || ffact[l] !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_results lane%0d: got cnt=%0d addr=%0d exp=%h act=%h want all 0",
                         l, fail_count[l], ffa[l], ffe[l], ffact[l]);
            end
        end
    endtask

    task automatic test_clean();
        int ops, de, rpg, werr; logic b1;
        do_run(0, -1, ops, de, rpg, b1, werr);
        tests_run++;
        if (b1 !== 1'b1) begin tests_failed++; $display("FAIL clean_busy_edge1: got %0b want 1", b1); end
        tests_run++;
        if (ops !== 16) begin tests_failed++; $display("FAIL clean_ops: got %0d want 16", ops); end
        tests_run++;
        if (de !== 19) begin tests_failed++; $display("FAIL clean_done_edge: got %0d want 19", de); end
        tests_run++;
        if (pass[0] !== 1'b1 || fail_count[0] !== 16'd0) begin
            tests_failed++; $display("FAIL clean_result: got pass=%0b cnt=%0d want pass=1 cnt=0", pass[0], fail_count[0]);
        end
    endtask

    task automatic test_fault(input string name, input int lane, input int exp_cnt,
                              input logic [1:0] exp_addr, input logic [7:0] exp_act, input int exp_de);
        int ops, de, rpg, werr; logic b1;
        do_run(lane, -1, ops, de, rpg, b1, werr);
        tests_run++;
        if (de !== exp_de || pass[lane] !== 1'b0) begin
            tests_failed++; $display("FAIL %s_done: got edge=%0d pass=%0b want edge=%0d pass=0", name, de, pass[lane], exp_de);
        end
        tests_run++;
        if (fail_count[lane] !== 16'(exp_cnt)) begin
            tests_failed++; $display("FAIL %s_count: got %0d want %0d", name, fail_count[lane], exp_cnt);
        end
        tests_run++;
        if (ffa[lane] !== exp_addr || ffe[lane] !== 8'hFF || ffact[lane] !== exp_act) begin
            tests_failed++;
            $display("FAIL %s_first: got addr=%0d exp=%h act=%h want addr=%0d exp=ff act=%h",
                     name, ffa[lane], ffe[lane], ffact[lane], exp_addr, exp_act);
        end
    endtask

    task automatic test_rerun_from_done();
        int ops, de, rpg, werr; logic b1;
        clear_faults();
        do_run(0, 5, ops, de, rpg, b1, werr);
        tests_run++;
        if (rpg !== 1 || ops !== 16) begin
            tests_failed++; $display("FAIL rerun_ignore_start: got resets=%0d ops=%0d want 1 and 16", rpg, ops);
        end
        tests_run++;
        if (de !== 19 || pass[0] !== 1'b1 || fail_count[0] !== 16'd0) begin
            tests_failed++; $display("FAIL rerun_result: got edge=%0d pass=%0b cnt=%0d want 19/1/0", de, pass[0], fail_count[0]);
        end
        tests_run++;
        if (ffa[0] !== 2'd0 || ffe[0] !== 8'd0 || ffact[0] !== 8'd0) begin
            tests_failed++; $display("FAIL rerun_first_cleared: got addr=%0d exp=%h act=%h want 0", ffa[0], ffe[0], ffact[0]);
        end
    endtask

    task automatic test_func_traffic();
        int ops, de, rpg, werr; logic b1;
        func_addr = 2'd1; func_wdata = 8'h77; func_wmask = 1'b1; func_we = 1'b1;
        do_run(0, -1, ops, de, rpg, b1, werr);
        tests_run++;
        if (werr !== 0) begin tests_failed++; $display("FAIL func_busy_mux: got %0d bad cycles want 0", werr); end
        tests_run++;
        if (pass[0] !== 1'b1 || de !== 19) begin
            tests_failed++; $display("FAIL func_pass: got pass=%0b edge=%0d want 1/19", pass[0], de);
        end
        tests_run++;
        if (func_grant[0] !== 1'b1 || sram_we[0] !== 1'b1 || sram_addr[0] !== 2'd1 || sram_wdata[0] !== 8'h77) begin
            tests_failed++;
            $display("FAIL func_after_done: got grant=%0b we=%0b addr=%0d wdata=%h want 1/1/1/77",
                     func_grant[0], sram_we[0], sram_addr[0], sram_wdata[0]);
        end
        func_we = 1'b0;
    endtask

    task automatic test_rst_mid_run();
        int ops, de, rpg, werr; logic b1;
        stuck[0][0] = 8'hFF;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (8) tick();
        tests_run++;
        if (busy[0] !== 1'b1 || pg_addr[0] !== 2'd3 || sram_re[0] !== 1'b1) begin
            tests_failed++; $display("FAIL rst_pre_op7: got busy=%0b addr=%0d re=%0b want 1/3/1", busy[0], pg_addr[0], sram_re[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || fail_count[0] !== 16'd0 || func_grant[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_abort: got busy=%0b done=%0b cnt=%0d grant=%0b want 0/0/0/1",
                     busy[0], done[0], fail_count[0], func_grant[0]);
        end
        clear_faults();
        do_run(0, -1, ops, de, rpg, b1, werr);
        tests_run++;
        if (de !== 19 || pass[0] !== 1'b1 || ops !== 16) begin
            tests_failed++; $display("FAIL rst_restart: got edge=%0d pass=%0b ops=%0d want 19/1/16", de, pass[0], ops);
        end
    endtask

    task automatic test_latency3_clean();
        int ops, de, rpg, werr; logic b1;
        do_run(1, -1, ops, de, rpg, b1, werr);
        tests_run++;
        if (de !== 21 || pass[1] !== 1'b1 || ops !== 16) begin
            tests_failed++; $display("FAIL lat3_clean: got edge=%0d pass=%0b ops=%0d want 21/1/16", de, pass[1], ops);
        end
    endtask

    initial begin
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        func_addr = 2'd0; func_wdata = 8'h00; func_wmask = 1'b0; func_we = 1'b0; func_re = 1'b0;
        clear_faults();
        repeat (3) tick();
        test_reset();
        test_clean();
        stuck[0][2] = 8'h08;
        test_fault("stuck_bit3", 0, 1, 2'd2, 8'hF7, 19);
        test_rerun_from_done();
        for (int a = 0; a < 4; a++) stuck[0][a] = 8'hFF;
        test_fault("stuck_all", 0, 4, 2'd0, 8'h00, 19);
        clear_faults();
        test_func_traffic();
        test_rst_mid_run();
        test_latency3_clean();
        stuck[1][3] = 8'h01;
        test_fault("lat3_addr3", 1, 1, 2'd3, 8'hFE, 21);
        clear_faults();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequences one SRAM macro through a built-in self-test driven by a deterministic pattern generator on a `det_patgen_if`.
- Arbitrates the SRAM port: the functional port owns it except while a test runs.
- Issues patgen ops to the SRAM and compares read data against the patgen's expected value after the macro's read latency.
- Reports pass/fail, a saturating failure count, and the first failing address and data.

Parameters:
- MAX_ADDR, 255: last address exercised; the patgen's MAX_ADDR.
- ADDR_WIDTH, $clog2(MAX_ADDR): address width.
- DATA_WIDTH, 32: data width.
- MASK_WIDTH, 4: write-mask width.
- READ_LATENCY, 1: cycles from sram_re high to valid sram_rdata; must be 1 or more.
- FAIL_CNT_WIDTH, 16: width of fail_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a test when the controller is in IDLE or DONE
- busy  out  1  high while a test is in progress (RESET_PG, RUN, DRAIN)
- done  out  1  high in DONE
- pass  out  1  valid when done=1; high iff fail_count==0
- fail_count  out  FAIL_CNT_WIDTH  number of mismatching reads; saturates at all-ones
- first_fail_addr  out  ADDR_WIDTH  address of the first mismatching read
- first_fail_expected  out  DATA_WIDTH  expected data at the first mismatch
- first_fail_actual  out  DATA_WIDTH  read data at the first mismatch
- pg_en, pg_rst  out  1  patgen enable and reset
- pg_addr  in  ADDR_WIDTH  patgen address
- pg_data, pg_check  in  DATA_WIDTH  patgen write data and expected read data
- pg_wmask  in  MASK_WIDTH  patgen write mask
- pg_we, pg_re, pg_done  in  1  patgen write, read and done
- func_addr, func_wdata, func_wmask, func_we, func_re  in  functional request
- func_grant  out  1  high when the functional request is forwarded to the SRAM
- sram_addr, sram_wdata, sram_wmask, sram_we, sram_re  out  SRAM request
- sram_rdata  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset drives: state IDLE, busy=0, done=0, pass=0, fail_count=0, all first_fail_* =0, read pipeline empty.
- pg_rst = rst | (state==RESET_PG).
- pg_en = (state==RUN) & !pg_done.
- States:
  - IDLE: start=1 -> RESET_PG.
  - RESET_PG: lasts one cycle. Clears fail_count, first_fail_* and the sticky first-fail flag. Next state RUN.
  - RUN: when pg_done=1 -> DRAIN. While pg_done=0, the patgen op is forwarded to the SRAM.
  - DRAIN: counts READ_LATENCY cycles, then -> DONE.
  - DONE: holds results. start=1 -> RESET_PG (new run). Otherwise stays.
- start is ignored while busy.
- rst at any cycle aborts immediately to IDLE. No partial results are retained.
- SRAM mux:
  - When busy=0: sram_* = func_*, func_grant=1.
  - When busy=1: sram_addr/wdata/wmask come from pg_*. sram_we = pg_we & (state==RUN) & !pg_done; sram_re likewise from pg_re. func_grant=0, and functional requests are dropped, not queued.
- Read check:
  - Each BIST read pushes {pg_addr, pg_check} into a READ_LATENCY-deep shift pipeline with a valid bit.
  - When a valid entry exits, sram_rdata is compared to its check value over all DATA_WIDTH bits.
  - On mismatch: fail_count increments, saturating. If no earlier failure has been recorded, the address, expected and actual values are latched into first_fail_*.
  - Functional reads never enter the pipeline.
- DRAIN guarantees the last read is checked before done rises. A read issued in the final RUN cycle completes in the final DRAIN cycle.
- pass = done & (fail_count==0). pass is 0 when not done.

Decomposition:
- Shared package bist_pkg holds typedef enum logic [2:0] bist_ctrl_state_t {IDLE, RESET_PG, RUN, DRAIN, DONE}.
- One sub-module, bist_read_checker: latency pipeline, comparator, fail counter and first-fail capture. Its controls are clear and push.

Test Plan:
All scenarios use a zero/one patgen, MAX_ADDR=3, DATA_WIDTH=8, MASK_WIDTH=1, READ_LATENCY=1, and an ideal SRAM model unless stated.
- Clean run: start pulsed at edge 0 -> busy=1 from edge 1, 16 SRAM ops, done=1 and pass=1 at edge 19, fail_count=0.
- Stuck-at-0 bit 3 at addr 2: start -> done, pass=0, fail_count=1, first_fail_addr=2, expected=8'hFF, actual=8'hF7.
- Stuck-at-0 all bits at every addr: fail_count=4; first_fail_addr=0, expected=8'hFF, actual=8'h00.
- Functional traffic during the test: func_we=1 held throughout -> func_grant=0 and sram_we matches pg_we while busy; after done, func_grant=1 and sram_we=1.
- rst asserted mid-RUN at op 7 -> next cycle IDLE, busy=0, done=0, fail_count=0. A new start completes a clean run with pass=1.
- start pulsed in DONE after a failing run -> results cleared in RESET_PG; with the fault removed, the rerun gives pass=1. start pulsed again during RUN is ignored: no extra RESET_PG and the op count stays 16.
- READ_LATENCY=3 variant: clean run -> done at edge 21 with pass=1. Fault at addr 3 -> first_fail_addr=3.
